// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - 16-way round-robin arbiter driving a 4-to-16 decoder index/enable
// A grant holds until done, request withdrawal, or HOLD cycles elapse.
module rr_index_arbiter #(
  parameter int HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  i,
  output logic        en,
  output logic        tmo
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ptr, w_ptr_nxt;
  logic [3:0]  r_i, w_i_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_tmo, w_tmo_nxt;
  logic [3:0]  w_win;
  logic        w_any;

  // First set request at or above r_ptr, wrapping 15 -> 0.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!w_any && req[r_ptr + 4'(k)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 4'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_i_nxt     = r_i;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_i_nxt     = w_win;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_GRANT: begin
        if (done || !req[r_i] || (r_cnt == CNT_LAST)) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_i + 4'd1;
          w_cnt_nxt   = 8'd0;
          // Only a pure hold-limit release is reported as a timeout.
          w_tmo_nxt   = !done && req[r_i];
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 4'd0;
      r_i     <= 4'd0;
      r_cnt   <= 8'd0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_i     <= w_i_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign i   = r_i;
  assign en  = (r_state == S_GRANT);
  assign tmo = r_tmo;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - directed and random checks of rr_index_arbiter against a behavioural model
module tb_rr_index_arbiter;
  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  i;
  logic        en;
  logic        tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the grant, how many cycles it has been held, next starting slot.
  bit m_busy;
  int m_i;
  int m_ptr;
  int m_len;
  bit m_tmo;

  rr_index_arbiter #(.HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .i     (i),
    .en    (en),
    .tmo   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_i    = 0;
    m_ptr  = 0;
    m_len  = 0;
    m_tmo  = 1'b0;
  endtask

  task automatic model_edge();
    bit limit;
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (req != 16'h0000) begin
        for (int k = 0; k < 16; k++) begin
          if (req[(m_ptr + k) % 16]) begin
            m_i = (m_ptr + k) % 16;
            break;
          end
        end
        m_busy = 1'b1;
        m_len  = 1;
      end
    end else begin
      limit = (m_len == HOLD);
      if (done || !req[m_i] || limit) begin
        m_tmo  = limit && !done && req[m_i];
        m_busy = 1'b0;
        m_ptr  = (m_i + 1) % 16;
        m_len  = 0;
      end else begin
        m_len = m_len + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("model_en", 16'(en), 16'(m_busy));
    check("model_i", 16'(i), 16'(m_i));
    check("model_tmo", 16'(tmo), 16'(m_tmo));
  endtask

  task automatic grant_release(input int exp_i);
    step();
    check("rr_en", 16'(en), 16'd1);
    check("rr_i", 16'(i), 16'(exp_i));
    done = 1'b1;
    step();
    check("rr_gap_en", 16'(en), 16'd0);
    done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    model_reset();
    #2;
    check("reset_en", 16'(en), 16'd0);
    check("reset_i", 16'(i), 16'd0);
    check("reset_tmo", 16'(tmo), 16'd0);
    step();
    step();
    rst_n = 1'b1;

    repeat (10) step();
    check("idle_en", 16'(en), 16'd0);

    // Single request, done three cycles into the grant, then regrant of the same slot.
    req = 16'h0040;
    step();
    check("single_i", 16'(i), 16'd6);
    step();
    step();
    check("single_en_held", 16'(en), 16'd1);
    done = 1'b1;
    step();
    check("single_release", 16'(en), 16'd0);
    done = 1'b0;
    step();
    check("single_regrant_en", 16'(en), 16'd1);
    check("single_regrant_i", 16'(i), 16'd6);
    req = 16'h0000;
    step();

    // Full request from a fresh pointer: 0..15 then wrap to 0,1.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    req = 16'hFFFF;
    for (int g = 0; g < 18; g++) grant_release(g % 16);

    // Pointer wrap past 15.
    req = 16'h4000;
    grant_release(14);
    req = 16'h8003;
    grant_release(15);
    grant_release(0);
    grant_release(1);

    // Hold-limit timeout.
    req = 16'h0100;
    step();
    check("tmo_grant_i", 16'(i), 16'd8);
    for (int c = 0; c < HOLD - 1; c++) begin
      step();
      check("tmo_en_held", 16'(en), 16'd1);
    end
    step();
    check("tmo_en_drop", 16'(en), 16'd0);
    check("tmo_pulse", 16'(tmo), 16'd1);
    step();
    check("tmo_regrant_en", 16'(en), 16'd1);
    check("tmo_regrant_i", 16'(i), 16'd8);
    check("tmo_cleared", 16'(tmo), 16'd0);
    req = 16'h0000;
    step();

    // Withdrawal releases without timeout.
    req = 16'h0008;
    step();
    check("wd_i", 16'(i), 16'd3);
    step();
    req = 16'h0000;
    step();
    check("wd_en", 16'(en), 16'd0);
    check("wd_tmo", 16'(tmo), 16'd0);

    // done coinciding with the hold limit.
    req = 16'h0008;
    step();
    step();
    step();
    step();
    done = 1'b1;
    step();
    check("done_limit_en", 16'(en), 16'd0);
    check("done_limit_tmo", 16'(tmo), 16'd0);
    done = 1'b0;
    req  = 16'h0000;
    step();

    // Asynchronous reset in the middle of a grant.
    req = 16'h0020;
    step();
    check("async_pre_i", 16'(i), 16'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_en", 16'(en), 16'd0);
    check("async_i", 16'(i), 16'd0);
    model_reset();
    step();
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) req = 16'($urandom) & 16'($urandom);
      done = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
